// File: rtl/fifo_pkg.sv
// Shared constants and the one-hot token rotate helper for the token-ring FIFO.
package fifo_pkg;

    localparam int N_CELLS_DEF    = 16;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int TOKEN_MAX      = 64;

    // Rotate a one-hot token left by one within the low n_cells bits; the top bit wraps to bit 0.
    function automatic logic [TOKEN_MAX-1:0] token_rotate(input logic [TOKEN_MAX-1:0] tok,
                                                          input int                   n_cells);
        logic [TOKEN_MAX-1:0] top_bit;
        logic [TOKEN_MAX-1:0] r;
        top_bit = TOKEN_MAX'(1) << (n_cells - 1);
        r       = (tok << 1) & ~(top_bit << 1);
        if ((tok & top_bit) != '0) begin
            r = r | TOKEN_MAX'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_cell.sv
// One storage cell of the token-ring FIFO: a data register plus its occupied flag.
module fifo_cell
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  put_en,
    input  logic                  get_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  full
);

    // put_en and get_en never coincide: the tokens only share a cell at full or empty,
    // where one of the two requests is already rejected upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            full <= 1'b0;
        end else begin
            if (put_en) begin
                data <= data_in;
                full <= 1'b1;
            end else if (get_en) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fifo_cell_array.sv
// Token-ring FIFO storage: N_CELLS cells addressed by rotating one-hot put/get tokens.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_FLAG_EN is defined.
module fifo_cell_array
    import fifo_pkg::*;
#(
    parameter int N_CELLS    = N_CELLS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  put,
    input  logic [DATA_WIDTH-1:0] data_put,
    input  logic                  get,
    output logic [DATA_WIDTH-1:0] data_get,
    output logic                  valid_get,
    output logic [N_CELLS-1:0]    f_o,
    input  logic                  full_i,
    input  logic                  empty_i,
    output logic                  overflow,
    output logic                  underflow
);

    logic                  put_acc;
    logic                  get_acc;
    logic [N_CELLS-1:0]    put_tok;
    logic [N_CELLS-1:0]    get_tok;
    logic [DATA_WIDTH-1:0] cell_data [N_CELLS];
    logic [DATA_WIDTH-1:0] rd_data;

    // full_i/empty_i come back combinationally from the detectors fed by f_o.
    assign put_acc = put & ~full_i;
    assign get_acc = get & ~empty_i;

    for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
        fifo_cell #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .put_en (put_acc & put_tok[i]),
            .get_en (get_acc & get_tok[i]),
            .data_in(data_put),
            .data   (cell_data[i]),
            .full   (f_o[i])
        );
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (get_tok[i]) begin
                rd_data = rd_data | cell_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            put_tok   <= N_CELLS'(1);
            get_tok   <= N_CELLS'(1);
            data_get  <= '0;
            valid_get <= 1'b0;
        end else begin
            valid_get <= get_acc;
            if (put_acc) begin
                put_tok <= N_CELLS'(token_rotate(TOKEN_MAX'(put_tok), N_CELLS));
            end
            if (get_acc) begin
                get_tok  <= N_CELLS'(token_rotate(TOKEN_MAX'(get_tok), N_CELLS));
                data_get <= rd_data;
            end
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (put & full_i);
            underflow <= underflow | (get & empty_i);
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_cell_array.sv
// Self-checking bench for fifo_cell_array with behavioural full/empty detectors and a queue model.
module tb_fifo_cell_array;

    localparam int N  = 16;
    localparam int DW = 8;
`ifdef FIFO_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          put;
    logic [DW-1:0] data_put;
    logic          get;
    logic [DW-1:0] data_get;
    logic          valid_get;
    logic [N-1:0]  f_o;
    logic          full_i;
    logic          empty_i;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_exp;
    int            gp;
    int            cnt;
    logic          ovf_m;
    logic          udf_m;

    fifo_cell_array #(
        .N_CELLS   (N),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .put      (put),
        .data_put (data_put),
        .get      (get),
        .data_get (data_get),
        .valid_get(valid_get),
        .f_o      (f_o),
        .full_i   (full_i),
        .empty_i  (empty_i),
        .overflow (overflow),
        .underflow(underflow)
    );

    assign full_i  = &f_o;
    assign empty_i = ~|f_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] f_model();
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < cnt; k++) begin
            r = r | (N'(1) << ((gp + k) % N));
        end
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        last_exp = '0;
        gp       = 0;
        cnt      = 0;
        ovf_m    = 1'b0;
        udf_m    = 1'b0;
    endtask

    // Called just after a rising edge; drives one cycle of requests and checks the result.
    task automatic do_cycle(input logic p, input logic [DW-1:0] d, input logic g);
        logic pa;
        logic ga;
        pa = p && (cnt != N);
        ga = g && (cnt != 0);
        if (ERR_EN) begin
            ovf_m = ovf_m | (p && (cnt == N));
            udf_m = udf_m | (g && (cnt == 0));
        end
        if (ga) begin
            exp_q.push_back(mq.pop_front());
            gp  = (gp + 1) % N;
            cnt = cnt - 1;
        end
        if (pa) begin
            mq.push_back(d);
            cnt = cnt + 1;
        end
        put      = p;
        data_put = d;
        get      = g;
        @(posedge clk);
        #1;
        put = 1'b0;
        get = 1'b0;
        check("f_o", 32'(f_o), 32'(f_model()));
        check("valid_get", 32'(valid_get), 32'(ga));
        if (valid_get && exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
        end
        check("data_get", 32'(data_get), 32'(last_exp));
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("underflow", 32'(underflow), 32'(udf_m));
    endtask

    initial begin
        put      = 1'b0;
        get      = 1'b0;
        data_put = '0;
        rst_n    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_f_o", 32'(f_o), 32'h0);
        check("rst_data_get", 32'(data_get), 32'h0);
        check("rst_valid_get", 32'(valid_get), 32'h0);
        check("rst_empty_i", 32'(empty_i), 32'h1);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);

        // Fill, then one rejected put at full
        for (int i = 1; i <= N; i++) do_cycle(1'b1, DW'(i), 1'b0);
        check("fill_full", 32'(f_o), 32'hFFFF);
        do_cycle(1'b1, 8'hFF, 1'b0);
        check("reject_put_f_o", 32'(f_o), 32'hFFFF);
        check("reject_put_ovf", 32'(overflow), 32'(ERR_EN));

        // Drain in order, then one rejected get at empty
        for (int i = 0; i < N; i++) do_cycle(1'b0, '0, 1'b1);
        check("drain_empty", 32'(f_o), 32'h0);
        do_cycle(1'b0, '0, 1'b1);
        check("reject_get_udf", 32'(underflow), 32'(ERR_EN));

        // At empty with put & get: only the put lands
        do_cycle(1'b1, 8'h3C, 1'b1);
        check("empty_both_f_o", 32'(f_o), 32'h0001);
        for (int i = 0; i < N - 1; i++) do_cycle(1'b1, DW'(8'h40 + i), 1'b0);
        // At full with put & get: only the get lands
        do_cycle(1'b1, 8'hEE, 1'b1);
        check("full_both_f_o", 32'(f_o), 32'hFFFE);
        for (int i = 0; i < N - 1; i++) do_cycle(1'b0, '0, 1'b1);

        // Interleaved traffic across the 15 -> 0 wrap
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1, DW'(8'hA0 + i), 1'b0);
            check("wrap_one_bit", 32'($countones(f_o)), 32'h1);
            do_cycle(1'b0, '0, 1'b1);
        end

        // Sustained simultaneous put/get away from the boundaries
        do_cycle(1'b1, 8'h11, 1'b0);
        do_cycle(1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 6; i++) do_cycle(1'b1, DW'(8'h60 + i), 1'b1);
        for (int i = 0; i < 2; i++) do_cycle(1'b0, '0, 1'b1);

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) do_cycle(1'b1, DW'(8'hC0 + i), 1'b0);
        do_cycle(1'b0, '0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_f_o", 32'(f_o), 32'h0);
        check("arst_data_get", 32'(data_get), 32'h0);
        check("arst_valid_get", 32'(valid_get), 32'h0);
        check("arst_overflow", 32'(overflow), 32'h0);
        check("arst_underflow", 32'(underflow), 32'h0);
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_cycle(1'b1, 8'h5A, 1'b0);
        check("post_rst_tok", 32'(f_o), 32'h0001);
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
